// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking slot manager.
// Optional lowest-free-slot reassignment: PARKING_AUTO_ALLOC_EN.
package parking_pkg;

  localparam int DEFAULT_NUM_SLOTS = 8;

  typedef enum logic [1:0] {
    IDLE,
    DECIDE,
    RESP
  } state_t;

  // $clog2 clamped to at least one bit
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/parking_first_free.sv
// Lowest-index free slot finder over the occupancy bitmap.
// Used only when PARKING_AUTO_ALLOC_EN is defined.
module parking_first_free
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = DEFAULT_NUM_SLOTS,
  parameter int LOC_W     = idx_w(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] occupancy,
  output logic                 found,
  output logic [LOC_W-1:0]     index
);

  // Scan high to low so the lowest zero wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupancy[i]) begin
        found = 1'b1;
        index = LOC_W'(i);
      end
    end
  end

endmodule

// File: rtl/parking_slot_manager.sv
// Parking slot manager: occupancy bitmap, entry FSM, exit releases.
// Define PARKING_AUTO_ALLOC_EN to reassign denied entries to a free slot.
module parking_slot_manager
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = DEFAULT_NUM_SLOTS,
  parameter int LOC_W     = idx_w(NUM_SLOTS),
  parameter int CNT_W     = idx_w(NUM_SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [LOC_W-1:0]     req_loc,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_granted,
  output logic [LOC_W-1:0]     resp_loc,
  input  logic                 rel_valid,
  input  logic [LOC_W-1:0]     rel_loc,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [CNT_W-1:0]     free_count,
  output logic                 full,
  output logic                 empty,
  output logic                 rel_error
);

  localparam logic [LOC_W:0] SLOTS_L = (LOC_W + 1)'(NUM_SLOTS);
  localparam logic [CNT_W-1:0] SLOTS_C = CNT_W'(NUM_SLOTS);

  state_t               state;
  logic [LOC_W-1:0]     lat_loc;
  logic [NUM_SLOTS-1:0] rel_mask;
  logic [NUM_SLOTS-1:0] occ_rel;
  logic [NUM_SLOTS-1:0] occ_next;
  logic [CNT_W-1:0]     free_next;
  logic                 rel_bad;
  logic                 rel_in_range;
  logic                 lat_in_range;
  logic                 lat_free;
  logic                 grant;
  logic [LOC_W-1:0]     grant_loc;

  assign rel_in_range = {1'b0, rel_loc} < SLOTS_L;
  assign lat_in_range = {1'b0, lat_loc} < SLOTS_L;

  always_comb begin
    rel_mask = '0;
    rel_bad  = 1'b0;
    if (rel_valid) begin
      if (rel_in_range && occupancy[rel_loc])
        rel_mask[rel_loc] = 1'b1;
      else
        rel_bad = 1'b1;
    end
  end

  // Release lands before the decision, so a same-cycle
  // release of the requested slot makes it grantable.
  assign occ_rel  = occupancy & ~rel_mask;
  assign lat_free = lat_in_range && !occ_rel[lat_loc];

`ifdef PARKING_AUTO_ALLOC_EN
  logic             ff_found;
  logic [LOC_W-1:0] ff_index;

  parking_first_free #(
    .NUM_SLOTS(NUM_SLOTS),
    .LOC_W    (LOC_W)
  ) u_first_free (
    .occupancy(occ_rel),
    .found    (ff_found),
    .index    (ff_index)
  );

  always_comb begin
    grant     = 1'b0;
    grant_loc = lat_loc;
    if (lat_free) begin
      grant = 1'b1;
    end else if (ff_found) begin
      grant     = 1'b1;
      grant_loc = ff_index;
    end
  end
`else
  assign grant     = lat_free;
  assign grant_loc = lat_loc;
`endif

  always_comb begin
    occ_next = occ_rel;
    if (state == DECIDE && grant)
      occ_next = occ_rel | (NUM_SLOTS'(1) << grant_loc);
  end

  always_comb begin
    free_next = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!occ_next[i])
        free_next = free_next + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occupancy  <= '0;
      free_count <= SLOTS_C;
      full       <= 1'b0;
      empty      <= 1'b1;
      rel_error  <= 1'b0;
    end else begin
      occupancy  <= occ_next;
      free_count <= free_next;
      full       <= (free_next == '0);
      empty      <= (free_next == SLOTS_C);
      if (rel_bad)
        rel_error <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      lat_loc      <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_granted <= 1'b0;
      resp_loc     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            lat_loc   <= req_loc;
            req_ready <= 1'b0;
            state     <= DECIDE;
          end
        end
        DECIDE: begin
          resp_valid   <= 1'b1;
          resp_granted <= grant;
          resp_loc     <= grant_loc;
          state        <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
